// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata while valid=1.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty, full, pop, wr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = pop_req && !empty;
  assign wr    = push && (!full || pop);

  // NOTE: storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge CLK) begin
    if (wr) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      ovf <= push && full && !pop;
    end
  end

  assign valid = !empty;
  assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: filtered KCLK/KDATA, framing/parity/timeout checks,
// E0/F0 prefix resolution, and a small event FIFO toward the ASCII stage.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       KCLK,
  input  logic       KDATA,
  input  logic       RD,
  output logic       KVALID,
  output logic [7:0] KCODE,
  output logic       KEXT,
  output logic       KBREAK,
  output logic       PERR,
  output logic       TOERR,
  output logic       OVF
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Index 0 carries KCLK, index 1 carries KDATA.
  logic [1:0]    meta, sync, filt;
  logic [FW-1:0] fcnt [2];
  logic          fe;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= 2'b11;
      sync <= 2'b11;
      filt <= 2'b11;
      fe   <= 1'b0;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      meta <= {KDATA, KCLK};
      sync <= meta;
      fe   <= filt[0] && !sync[0] && (fcnt[0] == FW'(FILT_LEN - 1));
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= sync[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  ps2_state_t    state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tocnt;
  logic          ext_flag, brk_flag;
  logic          push;
  ps2_evt_t      push_evt, head;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      bitcnt   <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tocnt    <= '0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      PERR     <= 1'b0;
      TOERR    <= 1'b0;
      push     <= 1'b0;
      push_evt <= '0;
    end else begin
      PERR  <= 1'b0;
      TOERR <= 1'b0;
      push  <= 1'b0;

      if (state == IDLE || fe) begin
        tocnt <= '0;
      end else if (tocnt == TW'(TIMEOUT_CYC - 1)) begin
        tocnt    <= '0;
        state    <= IDLE;
        bitcnt   <= '0;
        shreg    <= '0;
        TOERR    <= 1'b1;
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else begin
        tocnt <= tocnt + TW'(1);
      end

      if (fe) begin
        case (state)
          IDLE: begin
            if (!filt[1]) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {filt[1], shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= filt[1];
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (filt[1] && (^shreg ^ par_bit)) begin
              if (shreg == PS2_EXT_PREFIX) begin
                ext_flag <= 1'b1;
              end else if (shreg == PS2_BRK_PREFIX) begin
                brk_flag <= 1'b1;
              end else begin
                push     <= 1'b1;
                push_evt <= '{ext: ext_flag, brk: brk_flag, code: shreg};
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
              end
            end else begin
              PERR     <= 1'b1;
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_evt_t))
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push    (push),
    .wdata   (push_evt),
    .pop_req (RD),
    .valid   (KVALID),
    .rdata   (head),
    .ovf     (OVF)
  );

  assign {KEXT, KBREAK, KCODE} = KVALID ? head : '0;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: table of single frames plus hand sequences.
module tb_ps2_scan_rx;

  localparam int HP = 20;   // KCLK half period in CLK cycles
  localparam int TO = 400;  // shortened timeout for simulation

  logic       CLK = 1'b0, RST_N = 1'b0, KCLK = 1'b1, KDATA = 1'b1, RD = 1'b0;
  logic       KVALID, KEXT, KBREAK, PERR, TOERR, OVF;
  logic [7:0] KCODE;

  always #5 CLK = ~CLK;

  ps2_scan_rx #(.FILT_LEN(4), .TIMEOUT_CYC(TO), .FIFO_DEPTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .KCLK(KCLK), .KDATA(KDATA), .RD(RD),
    .KVALID(KVALID), .KCODE(KCODE), .KEXT(KEXT), .KBREAK(KBREAK),
    .PERR(PERR), .TOERR(TOERR), .OVF(OVF)
  );

  int n_checks = 0, n_fail = 0;
  int perr_cnt = 0, toerr_cnt = 0, ovf_cnt = 0;

  always @(negedge CLK) begin
    if (PERR)  perr_cnt++;
    if (TOERR) toerr_cnt++;
    if (OVF)   ovf_cnt++;
  end

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_push;
    bit         exp_ext;
    bit         exp_brk;
    bit         exp_perr;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] c, input bit bp, input bit bs);
    return {~bs, (~(^c)) ^ bp, c, 1'b0};
  endfunction

  // Bits go out LSB first; glitch_at selects a bit that gets 2-cycle KCLK glitches.
  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK) KDATA = bits[i];
      if (i == glitch_at) begin
        repeat (HP/2) @(negedge CLK);
        KCLK = 1'b0;
        repeat (2) @(negedge CLK);
        KCLK = 1'b1;
        repeat (HP/2 - 2) @(negedge CLK);
      end else begin
        repeat (HP) @(negedge CLK);
      end
      KCLK = 1'b0;
      if (i == glitch_at) begin
        repeat (HP/2) @(negedge CLK);
        KCLK = 1'b1;
        repeat (2) @(negedge CLK);
        KCLK = 1'b0;
        repeat (HP/2 - 2) @(negedge CLK);
      end else begin
        repeat (HP) @(negedge CLK);
      end
      KCLK = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input int glitch_at);
    send_bits(frame_bits(c, 1'b0, 1'b0), 11, glitch_at);
    repeat (HP) @(negedge CLK);
  endtask

  task automatic pop();
    @(negedge CLK) RD = 1'b1;
    @(negedge CLK) RD = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [7:0] c, input logic e, input logic b);
    check({name, "_kvalid"}, KVALID, 1);
    check({name, "_kcode"},  KCODE,  c);
    check({name, "_kext"},   KEXT,   e);
    check({name, "_kbreak"}, KBREAK, b);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, t0, o0;
    vecs[0]  = '{8'h1C, 0, 0, 1, 0, 0, 0};
    vecs[1]  = '{8'hE0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{8'hF0, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{8'h75, 0, 0, 1, 1, 1, 0};
    vecs[4]  = '{8'h75, 0, 0, 1, 0, 0, 0};
    vecs[5]  = '{8'h1C, 1, 0, 0, 0, 0, 1};
    vecs[6]  = '{8'h32, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{8'hF0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{8'h3A, 1, 0, 0, 0, 0, 1};
    vecs[9]  = '{8'h32, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{8'hE0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{8'h74, 0, 0, 1, 1, 0, 0};
    vecs[12] = '{8'hF0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{8'h29, 0, 0, 1, 0, 1, 0};
    vecs[14] = '{8'hE0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{8'h45, 0, 1, 0, 0, 0, 1};
    vecs[16] = '{8'h33, 0, 0, 1, 0, 0, 0};

    repeat (5) @(negedge CLK);
    check("reset_kvalid", KVALID, 0);
    check("reset_outputs", {KCODE, KEXT, KBREAK, PERR, TOERR, OVF}, 0);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);

    pop();
    check("rd_when_empty", KVALID, 0);

    foreach (vecs[i]) begin
      p0 = perr_cnt;
      send_bits(frame_bits(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop), 11, -1);
      repeat (HP) @(negedge CLK);
      check($sformatf("row%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr);
      if (vecs[i].exp_push) begin
        expect_head($sformatf("row%0d", i), vecs[i].code, vecs[i].exp_ext, vecs[i].exp_brk);
        pop();
      end
      check($sformatf("row%0d_empty", i), KVALID, 0);
    end
    check("table_no_ovf_toerr", ovf_cnt + toerr_cnt, 0);

    // Latency: nothing before the filter settles, event shortly after the stop-bit fall.
    send_bits(frame_bits(8'h4B, 1'b0, 1'b0), 10, -1);
    @(negedge CLK) KDATA = 1'b1;
    repeat (HP) @(negedge CLK);
    KCLK = 1'b0;
    repeat (5) @(negedge CLK);
    check("lat_not_early", KVALID, 0);
    for (int i = 0; i < 12 && !KVALID; i++) @(negedge CLK);
    expect_head("lat", 8'h4B, 0, 0);
    repeat (HP) @(negedge CLK);
    KCLK = 1'b1;
    pop();

    // Timeout after start + 4 data bits, then a clean frame.
    p0 = perr_cnt;
    t0 = toerr_cnt;
    send_bits(frame_bits(8'h55, 1'b0, 1'b0), 5, -1);
    repeat (TO/2) @(negedge CLK);
    check("to_not_early", toerr_cnt - t0, 0);
    repeat (TO) @(negedge CLK);
    check("toerr_once", toerr_cnt - t0, 1);
    check("to_no_perr", perr_cnt - p0, 0);
    check("to_no_event", KVALID, 0);
    send_frame(8'h29, -1);
    expect_head("after_to", 8'h29, 0, 0);
    pop();

    // Overflow: ninth event is dropped, first eight come out in order.
    o0 = ovf_cnt;
    for (int i = 1; i <= 8; i++) send_frame(8'(i), -1);
    check("ovf_not_early", ovf_cnt - o0, 0);
    send_frame(8'h09, -1);
    check("ovf_on_ninth", ovf_cnt - o0, 1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("fifo_pop%0d", i), {KVALID, KCODE}, {1'b1, 8'(i)});
      pop();
    end
    check("fifo_drained", KVALID, 0);

    // Glitches: idle KCLK pulses with KDATA low must not start a frame.
    p0 = perr_cnt;
    KDATA = 1'b0;
    repeat (3) begin
      @(negedge CLK) KCLK = 1'b0;
      repeat (2) @(negedge CLK);
      KCLK = 1'b1;
      repeat (10) @(negedge CLK);
    end
    KDATA = 1'b1;
    repeat (HP) @(negedge CLK);
    check("idle_glitch_none", KVALID, 0);
    send_frame(8'h5A, 3);
    check("glitch_no_perr", perr_cnt - p0, 0);
    expect_head("glitch_data", 8'h5A, 0, 0);
    pop();
    send_frame(8'h66, 9);
    expect_head("glitch_parity", 8'h66, 0, 0);
    pop();

    // Reset mid-frame with an event queued.
    send_frame(8'h16, -1);
    check("pre_reset_valid", KVALID, 1);
    p0 = perr_cnt;
    t0 = toerr_cnt;
    send_bits(frame_bits(8'h3C, 1'b0, 1'b0), 4, -1);
    @(negedge CLK) RST_N = 1'b0;
    #1;
    check("reset_mid_outputs", {KVALID, KCODE, KEXT, KBREAK, PERR, TOERR, OVF}, 0);
    KCLK  = 1'b1;
    KDATA = 1'b1;
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;
    repeat (TO + 50) @(negedge CLK);
    check("reset_no_err", (perr_cnt - p0) + (toerr_cnt - t0), 0);
    check("reset_fifo_empty", KVALID, 0);
    send_frame(8'h1E, -1);
    expect_head("after_reset", 8'h1E, 0, 0);
    pop();
    check("final_empty", KVALID, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
- PS/2 keyboard receiver. It turns raw KCLK/KDATA into complete, prefix-resolved scan-code events, with framing, parity and timeout checks.
- It sits directly upstream of the scan-code-to-ASCII stage, replacing the bare byte receiver.
- A small show-ahead FIFO buffers events, so the downstream consumer is not forced to act in the cycle a frame completes.

Parameters:
- FILT_LEN, 4: consecutive identical synchronized samples needed before filtered KCLK/KDATA change.
- TIMEOUT_CYC, 100000: CLK cycles without a KCLK falling edge, mid-frame, before the frame is aborted (2 ms at 50 MHz).
- FIFO_DEPTH, 8: event FIFO entries; must be a power of two.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- KCLK  in  1  raw PS/2 clock, asynchronous.
- KDATA  in  1  raw PS/2 data, asynchronous.
- RD  in  1  pop request; honoured only when KVALID=1.
- KVALID  out  1  FIFO non-empty; head event presented on KCODE/KEXT/KBREAK.
- KCODE  out  8  head event scan code.
- KEXT  out  1  head event was preceded by E0.
- KBREAK  out  1  head event was preceded by F0 (key release).
- PERR  out  1  one-cycle pulse: parity or stop-bit error; frame dropped.
- TOERR  out  1  one-cycle pulse: mid-frame timeout; frame dropped.
- OVF  out  1  one-cycle pulse: event lost because FIFO full.

Behaviour:
- Reset (RST_N=0, asynchronous): FSM=IDLE; shift register, bit count, timeout counter and prefix flags cleared; FIFO emptied.
  - All outputs 0 during reset.
  - Filtered KCLK/KDATA reset to 1 (bus idle).
- Input conditioning:
  - KCLK and KDATA each pass through a 2-FF synchronizer, then a FILT_LEN glitch filter.
  - The filtered value changes only after FILT_LEN consecutive equal samples.
  - A falling edge of filtered KCLK is detected as a one-cycle strobe FE.
- FSM, advancing only on FE:
  - IDLE: KDATA=0 -> DATA with bitcnt=0. KDATA=1 (no start bit) -> stay IDLE.
  - DATA: shift KDATA in LSB-first. After 8 bits -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: KDATA=1 and odd parity OK (data XOR parity = 1) -> byte accepted. Otherwise PERR pulses for one cycle. Either way -> IDLE.
- Timeout:
  - The counter runs in any state other than IDLE and clears on every FE.
  - On reaching TIMEOUT_CYC: FSM -> IDLE, partial byte discarded, TOERR pulses for one cycle.
  - The counter is held at 0 in IDLE.
- Prefix resolution on an accepted byte:
  - 0xE0 sets the ext flag; nothing pushed.
  - 0xF0 sets the brk flag; nothing pushed.
  - Any other byte B pushes {ext, brk, B}, then clears both flags.
  - PERR or TOERR also clears both flags.
  - E0, F0, B yields KEXT=1, KBREAK=1.
- Latency: the push is registered the cycle after the FE that sampled the stop bit. KVALID rises the following cycle.
- FIFO (10-bit entries, show-ahead):
  - Head is combinationally visible on KCODE/KEXT/KBREAK while KVALID=1. These outputs are 0 when the FIFO is empty.
  - RD with KVALID=1 pops at the next CLK edge. RD with KVALID=0 is ignored.
  - Full with push and no pop: the new event is dropped, OVF pulses, FIFO contents unchanged.
  - Full with simultaneous push and pop: both take effect; count unchanged, no OVF.
  - Empty with simultaneous push and RD: RD ignored; entry stored.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and the rest are equal.
- Reset asserted mid-frame: immediate abort, all state cleared, no error pulse. After release, reception resumes at the next start bit.

Decomposition:
- Package ps2_pkg:
  - constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0;
  - FSM state typedef {IDLE, DATA, PARITY, STOP};
  - event struct typedef {ext, brk, code[7:0]}.
- One sub-module: ps2_evt_fifo, a parameterized show-ahead synchronous FIFO with CLK/RST_N. The FSM, filter and timeout stay in ps2_scan_rx.

Test Plan:
- Send a frame with code 0x1C, parity 0, stop 1 at a 12.5 kHz KCLK -> KVALID=1, KCODE=0x1C, KEXT=0, KBREAK=0. RD=1 for one cycle -> KVALID=0.
- Send E0, F0, 0x75 -> exactly one event: KCODE=0x75, KEXT=1, KBREAK=1. Then send 0x75 alone -> KEXT=0, KBREAK=0.
- Send 0x1C with a wrong parity bit, then 0x32 -> PERR pulses once; only 0x32 is queued. Send F0, a bad-parity frame, then 0x32 -> KBREAK=0 on 0x32.
- Send 4 data bits, then hold KCLK high for TIMEOUT_CYC cycles -> TOERR pulses once, FSM in IDLE. The next full 0x29 frame is received correctly.
- Push 9 codes 0x01..0x09 with RD=0 -> OVF pulses on the 9th. Popping returns 0x01..0x08 in order, then KVALID=0.
- Inject 2-cycle KCLK glitches (with FILT_LEN=4) during IDLE and mid-frame -> no extra bits, correct code received. Assert RST_N=0 mid-frame -> outputs 0 immediately, no error pulse.
